// File: rtl/mesa_nib_decode_pkg.sv
// mesa_nib_decode_pkg: shared Mesa-Bus constants, decoder states and slot helpers
package mesa_nib_decode_pkg;
   localparam logic [7:0] MESA_PREAMBLE = 8'hF0;
   localparam logic [7:0] SLOT_BCAST    = 8'hFF;
   localparam logic [7:0] SLOT_NULL     = 8'hFE;
   localparam logic [7:0] SLOT_SELF     = 8'h00;

   typedef enum logic [2:0] {S_HUNT, S_SLOT, S_HDR, S_LEN, S_PAYLOAD} state_t;

   // A packet belongs to this node when addressed to slot 0 or broadcast
   function automatic logic slot_ours(input logic [7:0] s);
      return (s == SLOT_SELF) || (s == SLOT_BCAST);
   endfunction

   // Slot value as seen by the next node down the chain
   function automatic logic [7:0] slot_fwd(input logic [7:0] s);
      return (s == SLOT_SELF) ? SLOT_NULL :
             ((s == SLOT_BCAST) || (s == SLOT_NULL)) ? s : s - 8'd1;
   endfunction
endpackage

// File: rtl/mesa_byte_fifo.sv
// mesa_byte_fifo: small push/pop FIFO with first-word-fall-through read port
module mesa_byte_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_d,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_d,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
   logic             wr_ok, rd_ok;

   assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign empty = (wr_q == rd_q);
   assign pop_d = mem_q[rd_q[AW-1:0]];

   // A pop in the same cycle frees the slot, so a push while full is still accepted
   always_comb begin
      wr_ok = push && (!full || pop);
      rd_ok = pop && !empty;
      wr_d  = wr_q + (AW+1)'(wr_ok);
      rd_d  = rd_q + (AW+1)'(rd_ok);
   end

   // Pointer and storage update; reset empties the FIFO
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_q <= '0;
         rd_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
         if (wr_ok) mem_q[wr_q[AW-1:0]] <= push_d;
      end
   end
endmodule

// File: rtl/mesa_nib_decode.sv
// mesa_nib_decode: Mesa-Bus nibble aligner, header parser, local delivery and slot-rewriting forwarder
module mesa_nib_decode
   import mesa_nib_decode_pkg::*;
#(
   parameter int FIFO_DEPTH  = 4,
   parameter int TIMEOUT_CYC = 65535
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       nib_en,
   input  logic [3:0] nib_d,
   output logic       wo_byte_en,
   output logic [7:0] wo_byte_d,
   input  logic       wo_busy,
   output logic       loc_en,
   output logic [7:0] loc_d,
   output logic       loc_start,
   output logic       loc_stop,
   output logic [3:0] loc_subslot,
   output logic [3:0] loc_cmd,
   output logic       pkt_abort,
   output logic       fwd_overflow
);
   state_t      state_q, state_d;
   logic        phase_q, phase_d;
   logic [3:0]  hi_q, hi_d, prev_q, prev_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        first_q, first_d, ours_q, ours_d;
   logic [15:0] to_q, to_d;
   logic        loc_en_q, loc_en_d, loc_start_q, loc_start_d, loc_stop_q, loc_stop_d;
   logic [7:0]  loc_d_q, loc_d_d;
   logic [3:0]  sub_q, sub_d, cmd_q, cmd_d;
   logic        abort_q, abort_d, ovf_q, ovf_d, popped_q, popped_d;
   logic        preamble, byte_done, timeout, push, pop, full, empty;
   logic [7:0]  byte_w, push_d, fifo_q;

   assign byte_w    = {hi_q, nib_d};
   assign preamble  = (state_q == S_HUNT) && nib_en && (prev_q == 4'hF) && (nib_d == 4'h0);
   assign byte_done = (state_q != S_HUNT) && nib_en && phase_q;
   assign timeout   = (state_q != S_HUNT) && !nib_en && (to_q == 16'(TIMEOUT_CYC - 1));
   assign push      = preamble || byte_done;
   assign pop       = !empty && !wo_busy && !popped_q;

   // Next-state: preamble locks, each completed byte advances, timeout abandons
   always_comb begin
      state_d = state_q;
      if (timeout) state_d = S_HUNT;
      else if (preamble) state_d = S_SLOT;
      else if (byte_done)
         case (state_q)
            S_SLOT:    state_d = S_HDR;
            S_HDR:     state_d = S_LEN;
            S_LEN:     state_d = (byte_w == 8'h00) ? S_HUNT : S_PAYLOAD;
            S_PAYLOAD: state_d = (cnt_q == 8'd1) ? S_HUNT : S_PAYLOAD;
            default:   state_d = S_HUNT;
         endcase
   end

   // Datapath: nibble assembly, header latches, payload counter, delivery strobes, forward push
   always_comb begin
      phase_d     = (timeout || preamble) ? 1'b0 : byte_done ? 1'b0 :
                    (nib_en && state_q != S_HUNT) ? 1'b1 : phase_q;
      hi_d        = (nib_en && !phase_q) ? nib_d : hi_q;
      prev_d      = (state_q != S_HUNT) ? 4'h0 : nib_en ? (preamble ? 4'h0 : nib_d) : prev_q;
      cnt_d       = (byte_done && state_q == S_LEN) ? byte_w :
                    (byte_done && state_q == S_PAYLOAD) ? cnt_q - 8'd1 : cnt_q;
      first_d     = (byte_done && state_q == S_LEN) ? 1'b1 :
                    (byte_done && state_q == S_PAYLOAD) ? 1'b0 : first_q;
      ours_d      = (byte_done && state_q == S_SLOT) ? slot_ours(byte_w) : ours_q;
      sub_d       = (byte_done && state_q == S_HDR) ? byte_w[7:4] : sub_q;
      cmd_d       = (byte_done && state_q == S_HDR) ? byte_w[3:0] : cmd_q;
      loc_en_d    = byte_done && state_q == S_PAYLOAD && ours_q;
      loc_d_d     = loc_en_d ? byte_w : loc_d_q;
      loc_start_d = loc_en_d && first_q;
      loc_stop_d  = loc_en_d && cnt_q == 8'd1;
      to_d        = (nib_en || state_q == S_HUNT || timeout) ? 16'd0 : to_q + 16'd1;
      abort_d     = timeout;
      ovf_d       = ovf_q || (push && full && !pop);
      popped_d    = pop;
      push_d      = preamble ? MESA_PREAMBLE : (state_q == S_SLOT) ? slot_fwd(byte_w) : byte_w;
   end

   // State and output registers, all cleared by reset
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_HUNT;
         phase_q     <= 1'b0;
         hi_q        <= '0;
         prev_q      <= '0;
         cnt_q       <= '0;
         first_q     <= 1'b0;
         ours_q      <= 1'b0;
         to_q        <= '0;
         loc_en_q    <= 1'b0;
         loc_d_q     <= '0;
         loc_start_q <= 1'b0;
         loc_stop_q  <= 1'b0;
         sub_q       <= '0;
         cmd_q       <= '0;
         abort_q     <= 1'b0;
         ovf_q       <= 1'b0;
         popped_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         phase_q     <= phase_d;
         hi_q        <= hi_d;
         prev_q      <= prev_d;
         cnt_q       <= cnt_d;
         first_q     <= first_d;
         ours_q      <= ours_d;
         to_q        <= to_d;
         loc_en_q    <= loc_en_d;
         loc_d_q     <= loc_d_d;
         loc_start_q <= loc_start_d;
         loc_stop_q  <= loc_stop_d;
         sub_q       <= sub_d;
         cmd_q       <= cmd_d;
         abort_q     <= abort_d;
         ovf_q       <= ovf_d;
         popped_q    <= popped_d;
      end
   end

   mesa_byte_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fwd_fifo (
      .clk(clk), .reset_n(reset_n), .push(push), .push_d(push_d),
      .pop(pop), .pop_d(fifo_q), .full(full), .empty(empty)
   );

   assign wo_byte_en   = pop;
   assign wo_byte_d    = pop ? fifo_q : 8'h00;
   assign loc_en       = loc_en_q;
   assign loc_d        = loc_d_q;
   assign loc_start    = loc_start_q;
   assign loc_stop     = loc_stop_q;
   assign loc_subslot  = sub_q;
   assign loc_cmd      = cmd_q;
   assign pkt_abort    = abort_q;
   assign fwd_overflow = ovf_q;
endmodule

// File: tb/tb_mesa_nib_decode.sv
// tb_mesa_nib_decode: directed checks of alignment, slot rewrite, delivery, backpressure, timeout and reset
module tb_mesa_nib_decode;
   logic       clk = 1'b0, reset_n = 1'b0, nib_en = 1'b0, wo_busy = 1'b0;
   logic [3:0] nib_d = 4'h0;
   logic       wo_byte_en, loc_en, loc_start, loc_stop, pkt_abort, fwd_overflow;
   logic [7:0] wo_byte_d, loc_d;
   logic [3:0] loc_subslot, loc_cmd;

   int checks = 0, failures = 0;
   int cyc = 0, last_nib = 0, abort_cyc = 0, abort_n = 0, viol = 0;
   logic [7:0] wo_q [$];
   int         wo_t [$];
   logic [9:0] loc_q [$];

   mesa_nib_decode #(.FIFO_DEPTH(4), .TIMEOUT_CYC(100)) dut (
      .clk(clk), .reset_n(reset_n), .nib_en(nib_en), .nib_d(nib_d),
      .wo_byte_en(wo_byte_en), .wo_byte_d(wo_byte_d), .wo_busy(wo_busy),
      .loc_en(loc_en), .loc_d(loc_d), .loc_start(loc_start), .loc_stop(loc_stop),
      .loc_subslot(loc_subslot), .loc_cmd(loc_cmd),
      .pkt_abort(pkt_abort), .fwd_overflow(fwd_overflow)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (nib_en) last_nib = cyc + 1;
      if (wo_byte_en) begin
         wo_q.push_back(wo_byte_d);
         wo_t.push_back(cyc);
         if (wo_busy) viol++;
      end
      if (loc_en) loc_q.push_back({loc_start, loc_stop, loc_d});
      if (pkt_abort) begin
         abort_n++;
         abort_cyc = cyc;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [63:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) begin
         @(posedge clk); #1;
         nib_en = 1'b1;
         nib_d  = v[4*i +: 4];
      end
      @(posedge clk); #1;
      nib_en = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #3;
   endtask

   function automatic logic [63:0] pack_wo();
      logic [63:0] r = '0;
      foreach (wo_q[i]) r = (r << 8) | 64'(wo_q[i]);
      return r;
   endfunction

   function automatic logic [63:0] pack_loc();
      logic [63:0] r = '0;
      foreach (loc_q[i]) r = (r << 10) | 64'(loc_q[i]);
      return r;
   endfunction

   task automatic clear();
      wo_q.delete();
      wo_t.delete();
      loc_q.delete();
   endtask

   initial begin
      int gap;
      idle(3);
      chk("rst_outputs", {wo_byte_en, wo_byte_d, loc_en, loc_d, loc_start, loc_stop,
                          loc_subslot, loc_cmd, pkt_abort, fwd_overflow}, 64'h0);
      reset_n = 1'b1;
      idle(2);

      send(64'hF000_2302_ABCD, 12);
      idle(12);
      chk("t1_wo_n", wo_q.size(), 6);
      chk("t1_wo", pack_wo(), 64'hF0FE_2302_ABCD);
      chk("t1_loc_n", loc_q.size(), 2);
      chk("t1_loc", pack_loc(), 64'({10'h2AB, 10'h1CD}));
      chk("t1_sub_cmd", {loc_subslot, loc_cmd}, 8'h23);
      gap = 99;
      for (int i = 1; i < wo_t.size(); i++) if (wo_t[i] - wo_t[i-1] < gap) gap = wo_t[i] - wo_t[i-1];
      chk("t1_gap_ge2", gap >= 2, 1);
      clear();

      send(64'hF005_2301_77, 10);
      idle(12);
      chk("t2_wo", pack_wo(), 64'hF004_2301_77);
      chk("t2_loc_n", loc_q.size(), 0);
      clear();

      send(64'hF0FF_4501_99, 10);
      idle(12);
      chk("t3_wo", pack_wo(), 64'hF0FF_4501_99);
      chk("t3_loc", pack_loc(), 64'h399);
      chk("t3_sub_cmd", {loc_subslot, loc_cmd}, 8'h45);
      clear();

      send(64'h3FF0_0011_00, 10);
      idle(10);
      chk("t4_wo_n", wo_q.size(), 4);
      chk("t4_wo", pack_wo(), 64'hF0FE_1100);
      chk("t4_loc_n", loc_q.size(), 0);
      chk("t4_sub_cmd", {loc_subslot, loc_cmd}, 8'h11);
      clear();

      wo_busy = 1'b1;
      send(64'hF005_1202_3344, 12);
      idle(4);
      chk("t5_no_strobe_busy", wo_q.size(), 0);
      chk("t5_overflow", fwd_overflow, 1);
      wo_busy = 1'b0;
      idle(14);
      chk("t5_wo", pack_wo(), 64'hF004_1202);
      gap = 99;
      for (int i = 1; i < wo_t.size(); i++) if (wo_t[i] - wo_t[i-1] < gap) gap = wo_t[i] - wo_t[i-1];
      chk("t5_gap_ge2", gap >= 2, 1);
      chk("t5_overflow_sticky", fwd_overflow, 1);
      chk("busy_violations", viol, 0);
      clear();

      abort_n = 0;
      send(64'hF000_2305, 8);
      for (int i = 0; i < 200 && abort_n == 0; i++) idle(1);
      chk("t6_abort_n", abort_n, 1);
      chk("t6_abort_delay", abort_cyc - last_nib, 100);
      idle(3);
      chk("t6_abort_pulse", abort_n, 1);
      chk("t6_wo", pack_wo(), 64'hF0FE_2305);
      clear();
      send(64'hF000_6702_1122, 12);
      idle(12);
      chk("t6_wo_after", pack_wo(), 64'hF0FE_6702_1122);
      chk("t6_loc_after", pack_loc(), 64'({10'h211, 10'h122}));
      chk("t6_sub_cmd", {loc_subslot, loc_cmd}, 8'h67);
      clear();

      send(64'hF000_2303_AA, 10);
      chk("t7_loc_en_pre", {loc_en, loc_d}, 9'h1AA);
      reset_n = 1'b0;
      #1;
      chk("t7_rst_outputs", {wo_byte_en, wo_byte_d, loc_en, loc_d, loc_start, loc_stop,
                             loc_subslot, loc_cmd, pkt_abort, fwd_overflow}, 64'h0);
      idle(2);
      reset_n = 1'b1;
      idle(2);
      clear();
      send(64'hF000_8901_5A, 10);
      idle(12);
      chk("t7_wo_restart", pack_wo(), 64'hF0FE_8901_5A);
      chk("t7_loc_restart", pack_loc(), 64'h35A);
      chk("t7_sub_cmd", {loc_subslot, loc_cmd}, 8'h89);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
